cache_nway: RTL and testbench
=============================

# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache with integrated controller. It sits between the lc3b CPU memory port and physical memory, generalising the fixed two-way datapath. Way count, set count and line size are parameters. Victim selection uses tree pseudo-LRU, and valid, dirty and PLRU state are cleared by reset. Hit and miss performance counters are included.

## Interface
- NUM_WAYS, 4, associativity; power of two, 2..8
- INDEX_BITS, 3, set-index width; sets = 2^INDEX_BITS
- OFFSET_BITS, 4, byte-offset width; line = 8·2^OFFSET_BITS bits (default 128)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  16  byte address; tag = [15:INDEX_BITS+OFFSET_BITS]
- mem_wdata  in  16  write data
- mem_byte_enable  in  2  byte mask for writes; bit0 = [7:0], bit1 = [15:8]
- mem_rdata  out  16  read word; 0 whenever mem_resp = 0
- mem_resp  out  1  request complete, one cycle per request
- pmem_address  out  16  line address; low OFFSET_BITS bits = 0
- pmem_rdata  in  LINE  fill data, valid with pmem_resp
- pmem_wdata  out  LINE  writeback line
- pmem_read  out  1  fill request, held until pmem_resp
- pmem_write  out  1  writeback request, held until pmem_resp
- pmem_resp  in  1  one-cycle pulse, physical memory done
- hit_count  out  16  first-lookup hits, wraps at 0xFFFF to 0
- miss_count  out  16  misses, wraps at 0xFFFF to 0

## Operation
- Arrays are flop-based with asynchronous read. Per set and way: data, tag, valid, dirty. Per set: NUM_WAYS−1 PLRU bits.
- rst clears valid, dirty, PLRU, counters and the FSM. Data and tag arrays are not reset.
- Word select is mem_address[OFFSET_BITS-1:1]. Reads return the full word and ignore byte_enable.
- States are IDLE, WRITEBACK and FILL.
- IDLE, with mem_read or mem_write asserted:
  - Hit (valid and tag match in any way): mem_resp = 1 and mem_rdata = the selected word.
  - Hit with write: merge the enabled bytes into the line and set dirty.
  - Any hit: update PLRU at the edge.
  - Miss: register victim way and request tag, and increment miss_count.
  - Victim is the lowest-index invalid way if one exists, else the PLRU victim.
  - Next state is WRITEBACK if the victim is valid and dirty, else FILL.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read = 1, pmem_address = {request tag, index, 0}.
  - On pmem_resp, write the line and tag, set valid = 1 and dirty = 0, then go to IDLE.
  - The request then hits on re-lookup. That hit does not increment hit_count.
- Tree PLRU:
  - Node bit 0 means the victim is in the lower half; 1 means the upper half.
  - An access to way w sets every node on its path to point away from w.
- Simultaneous mem_read and mem_write is treated as a write.
- Changing mem_address before mem_resp is illegal and its behaviour is unspecified.
- Idle outputs: pmem_address = 0 and pmem_wdata = 0.

## Timing
- Reset values: mem_resp 0, mem_rdata 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, hit_count 0, miss_count 0.
- Hit latency: mem_resp is asserted combinationally in the first cycle the request is presented. Write data, dirty and PLRU commit at that cycle's edge.
- Clean miss: cycle 0 detects the miss; pmem_read is asserted from cycle 1 until pmem_resp. mem_resp comes one cycle after the pmem_resp cycle. Minimum total is 3 cycles.
- Dirty miss: add the WRITEBACK duration before FILL. pmem_read and pmem_write are never asserted together.
- Reset mid-miss: pmem_read and pmem_write drop asynchronously and the FSM returns to IDLE. All lines are invalid afterwards.
- Counter increment and wrap happen on the same edge as the event.

## Test plan
- After reset, read 0x0046: miss_count becomes 1 and pmem_read is asserted with pmem_address 0x0040. Supply a line with word3 = 0xABCD. Required: mem_resp with mem_rdata 0xABCD one cycle after pmem_resp, hit_count still 0.
- Re-read 0x0046: mem_resp in the same cycle with 0xABCD, hit_count = 1, no pmem activity.
- Write 0x1234 to 0x0046 with byte_enable 2'b01, then read it: 0xAB34 is returned, the line becomes dirty, no pmem activity.
- Access order (index 0):
  - Read 0x0000, 0x0080, 0x0100, 0x0180: these fill ways 0–3.
  - Write to 0x0100, then read 0x0180.
  - Read 0x0000: a hit.
  - Read 0x0200: the victim is way2.
  - Required: a writeback to pmem_address 0x0100 first, then a fill at 0x0200.
- Counter wrap: preload via 65535 hits, then one more hit gives hit_count = 0.
- Assert rst while pmem_write = 1: pmem_write drops the same cycle. A following read of 0x0046 misses, with pmem_read at 0x0040.

Source files
------------

// File: rtl/cache_nway_if.sv
// CPU-side and memory-side bus of the N-way cache. The cache is the slave.
// The master modport is the side that both issues CPU requests and plays
// physical memory, as a testbench or an SoC wrapper does.
interface cache_nway_if #(
    parameter int LINE = 128
);
    // CPU port
    logic            mem_read;
    logic            mem_write;
    logic [15:0]     mem_address;
    logic [15:0]     mem_wdata;
    logic [1:0]      mem_byte_enable;
    logic [15:0]     mem_rdata;
    logic            mem_resp;
    // physical memory port
    logic [15:0]     pmem_address;
    logic [LINE-1:0] pmem_rdata;
    logic [LINE-1:0] pmem_wdata;
    logic            pmem_read;
    logic            pmem_write;
    logic            pmem_resp;
    // performance counters
    logic [15:0]     hit_count;
    logic [15:0]     miss_count;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  hit_count, miss_count
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        output hit_count, miss_count
    );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache with tree
// pseudo-LRU replacement and hit/miss counters. Arrays are flops with
// asynchronous read; a hit responds in the same cycle it is presented.
module cache_nway #(
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    cache_nway_if.slave  bus
);
    localparam int LINE      = 8 * (2 ** OFFSET_BITS);
    localparam int SETS      = 2 ** INDEX_BITS;
    localparam int TAG_BITS  = 16 - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int WSEL_BITS = OFFSET_BITS - 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_t;

    state_t state_q, state_d;

    // storage; PLRU uses NUM_WAYS-1 tree nodes, top bit of each vector is spare
    logic [LINE-1:0]     data_q  [SETS][NUM_WAYS];
    logic [TAG_BITS-1:0] tag_q   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [NUM_WAYS-1:0] dirty_q [SETS];
    logic [NUM_WAYS-1:0] plru_q  [SETS];

    logic [WAY_BITS-1:0] victim_q;
    logic [TAG_BITS-1:0] rtag_q;
    logic                refill_q;   // next hit is the post-fill re-lookup
    logic [15:0]         hit_count_q;
    logic [15:0]         miss_count_q;

    // request decode
    logic                  req_s;
    logic                  wr_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [WSEL_BITS-1:0]  wsel_s;
    logic                  unused_s;

    assign req_s     = bus.mem_read | bus.mem_write;
    assign wr_s      = bus.mem_write;
    assign req_tag_s = bus.mem_address[15 -: TAG_BITS];
    assign index_s   = bus.mem_address[OFFSET_BITS +: INDEX_BITS];
    assign wsel_s    = bus.mem_address[OFFSET_BITS-1:1];
    assign unused_s  = bus.mem_address[0];

    logic                hit_s;
    logic [WAY_BITS-1:0] hit_way_s;
    logic                inv_found_s;
    logic [WAY_BITS-1:0] inv_way_s;
    logic [WAY_BITS-1:0] plru_way_s;
    logic [WAY_BITS-1:0] victim_s;
    logic                victim_dirty_s;
    logic [NUM_WAYS-1:0] plru_upd_s;
    logic [LINE-1:0]     line_s;
    logic [15:0]         word_s;
    logic [15:0]         new_word_s;
    logic [LINE-1:0]     wline_s;

    // tag compare and lowest-index invalid way search for the addressed set
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = ~(&valid_q[index_s]);
        inv_way_s   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_way_s = (valid_q[index_s][w] && (tag_q[index_s][w] == req_tag_s))
                        ? WAY_BITS'(w) : hit_way_s;
            inv_way_s = (!valid_q[index_s][w]) ? WAY_BITS'(w) : inv_way_s;
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_s = hit_s | (valid_q[index_s][w] && (tag_q[index_s][w] == req_tag_s));
        end
    end

    // walk the PLRU tree to the victim (node bit 1 = victim in upper half)
    always_comb begin
        logic [WAY_BITS-1:0] node;
        logic                b;
        node       = '0;
        b          = 1'b0;
        plru_way_s = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b          = plru_q[index_s][node];
            plru_way_s = WAY_BITS'({plru_way_s, b});
            node       = node + node + WAY_BITS'(1) + WAY_BITS'(b);
        end
        victim_s       = inv_found_s ? inv_way_s : plru_way_s;
        victim_dirty_s = valid_q[index_s][victim_s] & dirty_q[index_s][victim_s];
    end

    // new PLRU bits after an access to the hit way: every node on the path points away
    always_comb begin
        logic [WAY_BITS-1:0] node;
        logic [WAY_BITS-1:0] path;
        plru_upd_s = plru_q[index_s];
        node       = '0;
        path       = hit_way_s;
        for (int l = 0; l < WAY_BITS; l++) begin
            plru_upd_s[node] = ~path[WAY_BITS-1];
            node             = node + node + WAY_BITS'(1) + WAY_BITS'(path[WAY_BITS-1]);
            path             = path << 1;
        end
    end

    // word select and byte merge on the hit line
    always_comb begin
        line_s     = data_q[index_s][hit_way_s];
        word_s     = line_s[{wsel_s, 4'b0000} +: 16];
        new_word_s = {bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : word_s[15:8],
                      bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : word_s[7:0]};
        wline_s    = line_s;
        wline_s[{wsel_s, 4'b0000} +: 16] = new_word_s;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_s && !hit_s) begin
                    state_d = victim_dirty_s ? S_WRITEBACK : S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: state_d = bus.pmem_resp ? S_FILL : S_WRITEBACK;
            S_FILL:      state_d = bus.pmem_resp ? S_IDLE : S_FILL;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs: CPU response and physical memory requests
    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = 16'h0000;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 16'h0000;
        bus.pmem_wdata   = '0;
        case (state_q)
            S_IDLE: begin
                bus.mem_resp  = req_s & hit_s;
                bus.mem_rdata = (req_s & hit_s) ? word_s : 16'h0000;
            end
            S_WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[index_s][victim_q], index_s, {OFFSET_BITS{1'b0}}};
                bus.pmem_wdata   = data_q[index_s][victim_q];
            end
            S_FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {rtag_q, index_s, {OFFSET_BITS{1'b0}}};
            end
            default: begin
                bus.mem_resp = 1'b0;
            end
        endcase
    end

    // line state, PLRU, miss bookkeeping and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            victim_q     <= '0;
            rtag_q       <= '0;
            refill_q     <= 1'b0;
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_s && hit_s) begin
                        plru_q[index_s] <= plru_upd_s;
                        if (wr_s) begin
                            dirty_q[index_s][hit_way_s] <= 1'b1;
                        end
                        if (!refill_q) begin
                            hit_count_q <= hit_count_q + 16'd1;
                        end
                        refill_q <= 1'b0;
                    end else if (req_s) begin
                        victim_q     <= victim_s;
                        rtag_q       <= req_tag_s;
                        miss_count_q <= miss_count_q + 16'd1;
                    end
                end
                S_FILL: begin
                    if (bus.pmem_resp) begin
                        valid_q[index_s][victim_q] <= 1'b1;
                        dirty_q[index_s][victim_q] <= 1'b0;
                        refill_q                   <= 1'b1;
                    end
                end
                default: begin
                    refill_q <= refill_q;
                end
            endcase
        end
    end

    // data and tag arrays: write-hit merge and line fill
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_s && hit_s && wr_s) begin
            data_q[index_s][hit_way_s] <= wline_s;
        end else if (state_q == S_FILL && bus.pmem_resp) begin
            data_q[index_s][victim_q] <= bus.pmem_rdata;
            tag_q[index_s][victim_q]  <= rtag_q;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway (4 ways, 8 sets, 128-bit lines).
// Stimulus pushes expected CPU responses and physical-memory transactions;
// a monitor and a memory responder pop and compare them independently.
module tb_cache_nway;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_nway_if #(.LINE(128)) bus ();

    cache_nway #(.NUM_WAYS(4), .INDEX_BITS(3), .OFFSET_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [15:0] data;
    } resp_t;

    typedef struct {
        bit           we;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } pmem_t;

    resp_t       exp_q[$];
    pmem_t       pexp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          presp_cyc = -10;
    int          pmem_seen = 0;
    int          pmem_pushed = 0;
    bit          mem_hold = 1'b0;
    logic [15:0] exp_hits = 16'h0000;
    logic [15:0] exp_miss = 16'h0000;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] fill_line(input logic [15:0] a);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = a | 16'(w);
        if (a == 16'h0040) l[63:48] = 16'hABCD;
        return l;
    endfunction

    task automatic expect_pmem(input bit we, input logic [15:0] addr, input logic [127:0] wd);
        pmem_t p;
        p.we = we; p.addr = addr; p.wdata = wd;
        pexp_q.push_back(p);
        pmem_pushed++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // CPU response monitor
    always @(negedge clk) begin
        resp_t e;
        if (!rst && bus.mem_resp) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: got mem_resp with rdata %0h, expected none", bus.mem_rdata);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) check("mem_rdata", bus.mem_rdata, e.data);
            end
        end
    end

    // physical memory responder: one wait cycle, then a one-cycle pmem_resp
    initial begin
        pmem_t p;
        logic [15:0] a;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && !mem_hold && (bus.pmem_read || bus.pmem_write)) begin
                check("pmem_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
                a = bus.pmem_address;
                pmem_seen++;
                if (pexp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pmem: got we=%0b addr %0h, expected none", bus.pmem_write, a);
                end else begin
                    p = pexp_q.pop_front();
                    check("pmem_we", bus.pmem_write, p.we);
                    check("pmem_address", a, p.addr);
                    if (p.we) check("pmem_wdata", bus.pmem_wdata, p.wdata);
                end
                @(negedge clk);
                bus.pmem_rdata = fill_line(a);
                bus.pmem_resp  = 1'b1;
                presp_cyc      = cyc;
                @(posedge clk);
                #1;
                bus.pmem_resp  = 1'b0;
            end
        end
    end

    // one CPU request, held until mem_resp, then counters and pmem traffic checked
    task automatic access(input string nm, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          input bit chkd, input logic [15:0] exp, input bit miss);
        resp_t e;
        int    n;
        int    start;
        int    rc;
        bit    got;
        e.chk = chkd; e.data = exp;
        exp_q.push_back(e);
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        bus.mem_write       = we;
        bus.mem_read        = !we;
        start = cyc;
        got   = 1'b0;
        n     = 0;
        rc    = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.mem_resp;
            rc  = cyc;
            n++;
        end
        if (!got) begin
            check({nm, "_timeout"}, 1'b0, 1'b1);
        end else if (miss) begin
            check({nm, "_miss_latency"}, rc, presp_cyc + 1);
        end else begin
            check({nm, "_hit_latency"}, rc, start);
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (miss) exp_miss = exp_miss + 16'd1;
        else      exp_hits = exp_hits + 16'd1;
        check({nm, "_hit_count"}, bus.hit_count, exp_hits);
        check({nm, "_miss_count"}, bus.miss_count, exp_miss);
        check({nm, "_pmem_txns"}, pmem_seen, pmem_pushed);
    endtask

    // back-to-back hits with the read held high: one response per cycle
    task automatic hold_hits(input logic [15:0] addr, input int n, input logic [15:0] exp);
        resp_t e;
        e.chk = 1'b1; e.data = exp;
        bus.mem_address = addr;
        bus.mem_write   = 1'b0;
        bus.mem_read    = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            @(negedge clk);
            @(posedge clk);
            #1;
            exp_hits = exp_hits + 16'd1;
        end
        bus.mem_read = 1'b0;
    endtask

    initial begin
        logic [127:0] wb_line;
        int           n;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0000;
        bus.mem_wdata       = 16'h0000;
        bus.mem_byte_enable = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_resp", bus.mem_resp, 1'b0);
        check("rst_mem_rdata", bus.mem_rdata, 16'h0000);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_pmem_address", bus.pmem_address, 16'h0000);
        check("rst_pmem_wdata", bus.pmem_wdata, 128'h0);
        check("rst_hit_count", bus.hit_count, 16'h0000);
        check("rst_miss_count", bus.miss_count, 16'h0000);
        @(posedge clk);
        #1;

        // cold miss, then hits, then a byte write merged into the word
        expect_pmem(1'b0, 16'h0040, '0);
        access("rd46_miss", 1'b0, 16'h0046, 16'h0000, 2'b00, 1'b1, 16'hABCD, 1'b1);
        access("rd46_hit",  1'b0, 16'h0046, 16'h0000, 2'b00, 1'b1, 16'hABCD, 1'b0);
        access("wr46",      1'b1, 16'h0046, 16'h1234, 2'b01, 1'b0, 16'h0000, 1'b0);
        access("rd46_merged", 1'b0, 16'h0046, 16'h0000, 2'b00, 1'b1, 16'hAB34, 1'b0);

        // fill ways 0..3 of set 0, then steer PLRU so way2 is the victim
        expect_pmem(1'b0, 16'h0000, '0);
        access("fill_w0", 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1);
        expect_pmem(1'b0, 16'h0080, '0);
        access("fill_w1", 1'b0, 16'h0080, 16'h0000, 2'b00, 1'b1, 16'h0080, 1'b1);
        expect_pmem(1'b0, 16'h0100, '0);
        access("fill_w2", 1'b0, 16'h0100, 16'h0000, 2'b00, 1'b1, 16'h0100, 1'b1);
        expect_pmem(1'b0, 16'h0180, '0);
        access("fill_w3", 1'b0, 16'h0180, 16'h0000, 2'b00, 1'b1, 16'h0180, 1'b1);
        access("wr100",   1'b1, 16'h0100, 16'h5A5A, 2'b11, 1'b0, 16'h0000, 1'b0);
        access("rd180",   1'b0, 16'h0180, 16'h0000, 2'b00, 1'b1, 16'h0180, 1'b0);
        access("rd000",   1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0);
        wb_line = fill_line(16'h0100);
        wb_line[15:0] = 16'h5A5A;
        expect_pmem(1'b1, 16'h0100, wb_line);
        expect_pmem(1'b0, 16'h0200, '0);
        access("evict_w2", 1'b0, 16'h0200, 16'h0000, 2'b00, 1'b1, 16'h0200, 1'b1);

        // hit counter wrap
        n = 65535 - int'(exp_hits);
        hold_hits(16'h0000, n, 16'h0000);
        check("hit_count_max", bus.hit_count, 16'hFFFF);
        hold_hits(16'h0000, 1, 16'h0000);
        check("hit_count_wrap", bus.hit_count, 16'h0000);
        check("miss_count_after_wrap", bus.miss_count, exp_miss);

        // dirty every way of set 0 so the next miss must write back way3 (0x0180)
        access("dirty_w1", 1'b1, 16'h0080, 16'h1111, 2'b11, 1'b0, 16'h0000, 1'b0);
        access("dirty_w3", 1'b1, 16'h0180, 16'h3333, 2'b11, 1'b0, 16'h0000, 1'b0);
        access("dirty_w2", 1'b1, 16'h0200, 16'h2222, 2'b11, 1'b0, 16'h0000, 1'b0);
        access("dirty_w0", 1'b1, 16'h0000, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0);

        // reset in the middle of a writeback
        mem_hold            = 1'b1;
        bus.mem_address     = 16'h0280;
        bus.mem_read        = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.pmem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wb_pending", bus.pmem_write, 1'b1);
        check("wb_pending_addr", bus.pmem_address, 16'h0180);
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        #1;
        check("rst_drops_pmem_write", bus.pmem_write, 1'b0);
        check("rst_no_pmem_read", bus.pmem_read, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_hold = 1'b0;
        exp_hits = 16'h0000;
        exp_miss = 16'h0000;
        check("rst2_hit_count", bus.hit_count, 16'h0000);
        check("rst2_miss_count", bus.miss_count, 16'h0000);
        expect_pmem(1'b0, 16'h0040, '0);
        access("post_rst_miss", 1'b0, 16'h0046, 16'h0000, 2'b00, 1'b1, 16'hABCD, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
